// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: a word-addressed RAM with byte-enable
// stores. Each request gets a fixed wait-state latency and a one-cycle rdy/err response.
// Latency: LATENCY cycles from the accept edge to the rdy cycle. Backpressure: requests
// are sampled only in IDLE and are not queued, so the requester holds req until rdy.
// Ports: clk/rst (async, active-high); req/we/be/addr/wdata request; rdata/rdy/err/busy response.
module mc_mem_responder #(
    parameter int          ADDR_W  = 10,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdy,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    // The RAM access happens on the edge that enters RESP. With LATENCY=1 that is the accept
    // edge itself, so the live inputs are used instead of the (not yet captured) registers.
    logic              enter_resp;
    logic              op_we;
    logic [3:0]        op_be;
    logic [31:0]       op_addr;
    logic [31:0]       op_wdata;
    logic              op_err;
    logic [ADDR_W-1:0] op_idx;
    logic              ram_wr;

    always_comb begin
        enter_resp = ((state == IDLE) && req && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == 4'd1));
        if (state == IDLE) begin
            op_we    = we;
            op_be    = be;
            op_addr  = addr;
            op_wdata = wdata;
        end else begin
            op_we    = cap_we;
            op_be    = cap_be;
            op_addr  = cap_addr;
            op_wdata = cap_wdata;
        end
        // Misaligned, or outside the window: there is no aliasing of the upper address bits.
        op_err = (op_addr[1:0] != 2'b00) ||
                 (op_addr[31:ADDR_W+2] != BASE[31:ADDR_W+2]);
        op_idx = op_addr[ADDR_W+1:2];
        ram_wr = enter_resp && op_we && !op_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdy       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 32'h0;
            cap_we    <= 1'b0;
            cap_be    <= 4'h0;
            cap_addr  <= 32'h0;
            cap_wdata <= 32'h0;
        end else begin
            rdy <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_be    <= be;
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        busy      <= 1'b1;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                rdy <= 1'b1;
                err <= op_err;
                if (!op_we) begin
                    rdata <= op_err ? 32'h0 : mem[op_idx];
                end
            end
        end
    end

    // RAM contents survive reset; rst is in the sensitivity list only so that a reset landing
    // on the RESP-entry edge cancels the write instead of racing it.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench for mc_mem_responder: three instances (LATENCY 2, 3, 1) driven by
// directed scenarios and random transactions, compared against a word-array reference model.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_mc_mem_responder;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] WIN   = 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_v   [3];
    logic [31:0] rdata_v [3];
    logic        rdy_v   [3];
    logic        err_v   [3];
    logic        busy_v  [3];

    always #5 clk = ~clk;

    mc_mem_responder #(.ADDR_W(AW), .LATENCY(2), .BASE(32'h0)) u_l2 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[0]), .rdy(rdy_v[0]), .err(err_v[0]), .busy(busy_v[0]));
    mc_mem_responder #(.ADDR_W(AW), .LATENCY(3), .BASE(32'h0)) u_l3 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[1]), .rdy(rdy_v[1]), .err(err_v[1]), .busy(busy_v[1]));
    mc_mem_responder #(.ADDR_W(AW), .LATENCY(1), .BASE(32'h0)) u_l1 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[2]), .rdy(rdy_v[2]), .err(err_v[2]), .busy(busy_v[2]));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat_of [3] = '{2, 3, 1};
    logic [31:0] mdl_mem   [3][DEPTH];
    logic [31:0] last_load [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= WIN);
    endfunction

    // One complete transaction on instance d, checked for latency, err, rdata and pulse shape.
    task automatic txn(input int d, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd);
        bit e;
        int lat;
        int idx;
        e   = addr_bad(a);
        idx = int'(a / 4) % DEPTH;
        @(negedge clk);
        we = w; be = b; addr = a; wdata = wd; req_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_v[d] = 1'b0;
        chk("busy_inflight", 32'(busy_v[d]), 32'd1);
        lat = 1;
        while (!rdy_v[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_of[d]));
        chk("err", 32'(err_v[d]), 32'(e));
        if (!e && w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) mdl_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
        end else if (!w) begin
            last_load[d] = e ? 32'h0 : mdl_mem[d][idx];
        end
        chk("rdata", rdata_v[d], last_load[d]);
        @(negedge clk);
        chk("rdy_width", 32'(rdy_v[d]), 32'd0);
        chk("busy_end", 32'(busy_v[d]), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last_load[d] = 32'h0;
    endtask

    logic [31:0] ra;
    bit          rw;
    int          sel;

    initial begin
        rst = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 1'b0;
            last_load[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_rdy", 32'(rdy_v[d]), 32'd0);
            chk("rst_err", 32'(err_v[d]), 32'd0);
            chk("rst_busy", 32'(busy_v[d]), 32'd0);
            chk("rst_rdata", rdata_v[d], 32'h0);
        end
        rst = 1'b0;

        // Full-word init so every word the bench later reads has a known value.
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) txn(d, 1'b1, 4'hF, 32'(w * 4), $urandom);
            txn(d, 1'b1, 4'hF, 32'h0FFC, $urandom);
        end

        // Store/load, partial byte-enable, misaligned, out-of-range.
        txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0);
        chk("t1_load", rdata_v[0], 32'hDEADBEEF);
        txn(0, 1'b1, 4'b0011, 32'h10, 32'h12345678);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0);
        chk("t2_partial", rdata_v[0], 32'hDEAD5678);
        txn(0, 1'b0, 4'h0, 32'h12, 32'h0);
        txn(0, 1'b1, 4'hF, 32'h12, 32'hFFFFFFFF);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0);
        chk("t3_unchanged", rdata_v[0], 32'hDEAD5678);
        txn(0, 1'b0, 4'h0, 32'h1000, 32'h0);
        txn(0, 1'b0, 4'h0, 32'h0FFC, 32'h0);
        txn(0, 1'b1, 4'h0, 32'h10, 32'hA5A5A5A5);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0);

        // Held req on the LATENCY=3 instance: one accept every 4 cycles.
        @(negedge clk);
        we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h600DF00D; req_v[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_rdy", 32'(rdy_v[1]), 32'((i % 4) == 3));
            chk("hold_busy", 32'(busy_v[1]), 32'((i % 4) != 0));
        end
        req_v[1] = 1'b0;
        mdl_mem[1][16] = 32'h600DF00D;
        txn(1, 1'b0, 4'h0, 32'h40, 32'h0);

        // Reset during WAIT abandons the store.
        txn(0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h11111111; req_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last_load[d] = 32'h0;
        chk("rst_mid_rdata", rdata_v[0], 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_rdy", 32'(rdy_v[0]), 32'd0);
            chk("rst_mid_busy", 32'(busy_v[0]), 32'd0);
            @(negedge clk);
        end
        txn(0, 1'b0, 4'h0, 32'h20, 32'h0);

        // LATENCY=1: a request presented while reset is held is never accepted.
        txn(2, 1'b1, 4'hF, 32'h20, 32'h0BADCAFE);
        @(negedge clk);
        we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h22222222; req_v[2] = 1'b1; rst = 1'b1;
        @(negedge clk);
        req_v[2] = 1'b0;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last_load[d] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_l1_rdy", 32'(rdy_v[2]), 32'd0);
            chk("rst_l1_busy", 32'(busy_v[2]), 32'd0);
            @(negedge clk);
        end
        txn(2, 1'b0, 4'h0, 32'h20, 32'h0);

        // Random mix on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                sel = $urandom_range(0, 9);
                ra  = 32'($urandom_range(0, 15) * 4);
                if (sel == 7) ra = ra + 32'($urandom_range(1, 3));
                else if (sel == 8) ra = $urandom | 32'h1000;
                else if (sel == 9) ra = 32'h0FFC;
                rw = 1'($urandom_range(0, 1));
                txn(d, rw, 4'($urandom_range(0, 15)), ra, $urandom);
            end
        end

        pulse_reset();
        for (int d = 0; d < 3; d++) chk("final_rdata", rdata_v[d], last_load[d]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
